// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready pipelined signed ALU with flags and illegal-op counter
//   clk, rst_n         clock, async active-low reset
//   alu_en             global enable, 0 freezes every stage
//   in_valid/in_ready  upstream handshake for A, B, op
//   out_valid/out_ready downstream handshake for c, zero, neg, err
//   err_cnt            saturating count of accepted illegal opcodes
module alu_pipe #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   c,
    output logic             zero,
    output logic             neg,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);
    logic             s1_valid;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       op_q;
    logic             s2_adv;
    logic [WIDTH:0]   ax, bx, c_nx;
    assign s2_adv   = !out_valid || out_ready;
    // rst_n term keeps in_ready low while reset is held
    assign in_ready = rst_n && alu_en && (!s1_valid || s2_adv);
    always_comb begin
        ax = {a_q[WIDTH-1], a_q};
        bx = {b_q[WIDTH-1], b_q};
        case (op_q)
            4'd0:    c_nx = ax + bx;
            4'd1:    c_nx = ax - bx;
            4'd2:    c_nx = ax ^ bx;
            4'd3:    c_nx = ax | bx;
            4'd4:    c_nx = ax & bx;
            4'd5:    c_nx = ~(ax & bx);
            4'd6:    c_nx = ~(ax ^ bx);
            4'd7:    c_nx = ax - (WIDTH+1)'(1);
            4'd8:    c_nx = bx + (WIDTH+1)'(2);
            4'd9:    c_nx = ax;
            default: c_nx = '0;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            out_valid <= 1'b0;
            c         <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else if (alu_en) begin
            if (in_ready) begin
                s1_valid <= in_valid;
                a_q      <= A;
                b_q      <= B;
                op_q     <= op;
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    c    <= c_nx;
                    zero <= (c_nx == '0);
                    neg  <= c_nx[WIDTH];
                    err  <= (op_q > 4'd9);
                end
            end
            if (in_valid && in_ready && op > 4'd9 && err_cnt != '1)
                err_cnt <= err_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (WIDTH=5, CNT_W=2)
module tb_alu_pipe;
    logic       clk = 1'b0;
    logic       rst_n, alu_en, in_valid, in_ready, out_valid, out_ready;
    logic [4:0] A, B;
    logic [3:0] op;
    logic [5:0] c;
    logic       zero, neg, err;
    logic [1:0] err_cnt;
    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] v_op [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
    logic [4:0] v_a  [10] = '{5'd3, 5'd2, 5'd10, 5'd10, 5'h1F, 5'd7, 5'd5, 5'h10, 5'd0, 5'h1B};
    logic [4:0] v_b  [10] = '{5'd4, 5'd5, 5'd6, 5'h10, 5'd5, 5'd3, 5'd3, 5'd0, 5'd15, 5'd0};
    logic [5:0] v_c  [10] = '{6'h07, 6'h3D, 6'h0C, 6'h3A, 6'h05, 6'h3C, 6'h39, 6'h2F, 6'h11, 6'h3B};

    alu_pipe #(.WIDTH(5), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .alu_en(alu_en), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready), .c(c),
        .zero(zero), .neg(neg), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic [4:0] a, input logic [4:0] b);
        in_valid = v;
        op = o;
        A = a;
        B = b;
    endtask

    initial begin
        rst_n = 1'b0; alu_en = 1'b1; out_ready = 1'b1;
        drive(1'b0, 4'd0, 5'd0, 5'd0);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_c", 32'(c), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 1);
        // basic ADD / SUB with 2-cycle latency
        drive(1'b1, 4'd0, 5'd15, 5'd15);
        tick();
        drive(1'b0, 4'd0, 5'd0, 5'd0);
        chk("add_lat1_valid", 32'(out_valid), 0);
        tick();
        chk("add_valid", 32'(out_valid), 1);
        chk("add_c", 32'(c), 32'h1E);
        chk("add_neg", 32'(neg), 0);
        drive(1'b1, 4'd1, 5'h10, 5'd15);
        tick();
        drive(1'b0, 4'd0, 5'd0, 5'd0);
        tick();
        chk("sub_c", 32'(c), 32'h21);
        chk("sub_zero", 32'(zero), 0);
        chk("sub_neg", 32'(neg), 1);
        chk("sub_err", 32'(err), 0);
        tick();
        chk("drained_valid", 32'(out_valid), 0);
        // full-rate stream covering every legal opcode
        for (int t = 0; t < 12; t++) begin
            if (t < 10) begin
                drive(1'b1, v_op[t], v_a[t], v_b[t]);
                #0 chk($sformatf("stream_in_ready%0d", t), 32'(in_ready), 1);
            end else drive(1'b0, 4'd0, 5'd0, 5'd0);
            tick();
            chk($sformatf("stream_valid%0d", t), 32'(out_valid), 32'(t >= 1 && t <= 10));
            if (t >= 1 && t <= 10) chk($sformatf("stream_c%0d", t - 1), 32'(c), 32'(v_c[t - 1]));
        end
        // backpressure with both stages full
        out_ready = 1'b0;
        drive(1'b1, 4'd0, 5'd1, 5'd1);
        tick();
        drive(1'b1, 4'd0, 5'd2, 5'd2);
        tick();
        drive(1'b0, 4'd0, 5'd0, 5'd0);
        for (int t = 0; t < 3; t++) begin
            chk($sformatf("bp_in_ready%0d", t), 32'(in_ready), 0);
            chk($sformatf("bp_c%0d", t), 32'(c), 2);
            chk($sformatf("bp_valid%0d", t), 32'(out_valid), 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_rel_c1", 32'(c), 4);
        chk("bp_rel_valid1", 32'(out_valid), 1);
        tick();
        chk("bp_rel_empty", 32'(out_valid), 0);
        // illegal opcodes and counter saturation
        drive(1'b1, 4'd12, 5'd5, 5'd5);
        tick();
        drive(1'b0, 4'd0, 5'd0, 5'd0);
        chk("ill_cnt1", 32'(err_cnt), 1);
        tick();
        chk("ill_valid", 32'(out_valid), 1);
        chk("ill_c", 32'(c), 0);
        chk("ill_zero", 32'(zero), 1);
        chk("ill_neg", 32'(neg), 0);
        chk("ill_err", 32'(err), 1);
        for (int t = 0; t < 5; t++) begin
            drive(1'b1, 4'd15, 5'd1, 5'd1);
            tick();
        end
        drive(1'b0, 4'd0, 5'd0, 5'd0);
        chk("ill_cnt_sat", 32'(err_cnt), 3);
        tick();
        tick();
        chk("ill_sat_hold", 32'(err_cnt), 3);
        // alu_en=0 freezes a full pipe even with out_ready high
        out_ready = 1'b0;
        drive(1'b1, 4'd2, 5'd1, 5'd2);
        tick();
        drive(1'b1, 4'd8, 5'd0, 5'd4);
        tick();
        alu_en = 1'b0; out_ready = 1'b1;
        drive(1'b1, 4'd0, 5'd9, 5'd9);
        #0 chk("en0_in_ready", 32'(in_ready), 0);
        tick();
        tick();
        chk("en0_valid", 32'(out_valid), 1);
        chk("en0_c", 32'(c), 3);
        alu_en = 1'b1;
        drive(1'b0, 4'd0, 5'd0, 5'd0);
        tick();
        chk("en1_c2", 32'(c), 6);
        chk("en1_valid2", 32'(out_valid), 1);
        tick();
        chk("en1_empty", 32'(out_valid), 0);
        // asynchronous reset mid-stream
        drive(1'b1, 4'd0, 5'd3, 5'd3);
        tick();
        tick();
        drive(1'b0, 4'd0, 5'd0, 5'd0);
        chk("pre_rst_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_c", 32'(c), 0);
        chk("arst_err_cnt", 32'(err_cnt), 0);
        #1 rst_n = 1'b1;
        tick();
        drive(1'b1, 4'd0, 5'd5, 5'd6);
        tick();
        drive(1'b0, 4'd0, 5'd0, 5'd0);
        chk("post_rst_lat1", 32'(out_valid), 0);
        tick();
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_c", 32'(c), 11);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
